ysyx_exec_datapath: RTL and testbench



---
 rtl/ysyx_exec_pkg.sv | 34 +++
 rtl/ysyx_exec_datapath_rf32.sv | 50 +++++
 rtl/ysyx_exec_datapath.sv | 74 +++++++
 tb/tb_ysyx_exec_datapath.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_exec_pkg.sv
// Shared definitions for the execute-stage datapath: widths, register reset
// value, ALU operation codes and branch condition codes.
package ysyx_exec_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   localparam logic [XLEN-1:0] REG_RESET_VAL = 32'h0;

   // ALU operation codes; bit 3 selects the "alternate" form of ADD/SRL
   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b1000;
   localparam logic [3:0] ALU_SLL    = 4'b0001;
   localparam logic [3:0] ALU_SLT    = 4'b0010;
   localparam logic [3:0] ALU_SLTU   = 4'b0011;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_SRL    = 4'b0101;
   localparam logic [3:0] ALU_SRA    = 4'b1101;
   localparam logic [3:0] ALU_OR     = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_COPY_B = 4'b1111;

   // Branch condition codes
   localparam logic [2:0] BR_NEVER  = 3'b000;
   localparam logic [2:0] BR_ALWAYS = 3'b001;
   localparam logic [2:0] BR_EQ     = 3'b010;
   localparam logic [2:0] BR_NE     = 3'b011;
   localparam logic [2:0] BR_LT     = 3'b100;
   localparam logic [2:0] BR_GE     = 3'b101;
   localparam logic [2:0] BR_LTU    = 3'b110;
   localparam logic [2:0] BR_GEU    = 3'b111;

endpackage

// File: rtl/ysyx_exec_datapath_rf32.sv
// 32x32-bit register file with hardwired-zero x0, two asynchronous read
// ports and one synchronous write port.
// Optional write-through forwarding is enabled by defining YSYX_RF_BYPASS_EN.
module ysyx_rf32
   import ysyx_exec_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rf_wr_en,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs [NREG];

   // Storage: asynchronous clear of every entry, x0 is never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= REG_RESET_VAL;
         end
      end else if (rf_wr_en && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef YSYX_RF_BYPASS_EN
   logic fwd1;
   logic fwd2;

   // A pending write to the same non-zero index is forwarded before the edge
   always_comb begin
      fwd1 = rst_n && rf_wr_en && (waddr == raddr1);
      fwd2 = rst_n && rf_wr_en && (waddr == raddr2);
      rdata1 = (raddr1 == '0) ? REG_RESET_VAL : (fwd1 ? wdata : regs[raddr1]);
      rdata2 = (raddr2 == '0) ? REG_RESET_VAL : (fwd2 ? wdata : regs[raddr2]);
   end
`else
   // Plain asynchronous reads; x0 is forced to zero
   always_comb begin
      rdata1 = (raddr1 == '0) ? REG_RESET_VAL : regs[raddr1];
      rdata2 = (raddr2 == '0) ? REG_RESET_VAL : regs[raddr2];
   end
`endif

endmodule

// File: rtl/ysyx_exec_datapath.sv
// Execute-stage datapath: register file, ALU and branch-condition unit.
// Defining YSYX_RF_BYPASS_EN adds write-through forwarding in the register file.
module ysyx_exec_datapath
   import ysyx_exec_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rf_wr_en,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic [XLEN-1:0] alu_a,
   input  logic [XLEN-1:0] alu_b,
   input  logic [3:0]      alu_func,
   output logic [XLEN-1:0] alu_out,
   input  logic [2:0]      br_type,
   output logic            br_taken
);

   logic [4:0] shamt;

   ysyx_rf32 u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .rf_wr_en (rf_wr_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2)
   );

   assign shamt = alu_b[4:0];

   // ALU: wrap-around arithmetic, unknown codes produce zero
   always_comb begin
      alu_out = '0;
      case (alu_func)
         ALU_ADD:    alu_out = alu_a + alu_b;
         ALU_SUB:    alu_out = alu_a - alu_b;
         ALU_SLL:    alu_out = alu_a << shamt;
         ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
         ALU_XOR:    alu_out = alu_a ^ alu_b;
         ALU_SRL:    alu_out = alu_a >> shamt;
         ALU_SRA:    alu_out = $unsigned($signed(alu_a) >>> shamt);
         ALU_OR:     alu_out = alu_a | alu_b;
         ALU_AND:    alu_out = alu_a & alu_b;
         ALU_COPY_B: alu_out = alu_b;
         default:    alu_out = '0;
      endcase
   end

   // Branch condition: compares the two register read ports
   always_comb begin
      br_taken = 1'b0;
      case (br_type)
         BR_NEVER:  br_taken = 1'b0;
         BR_ALWAYS: br_taken = 1'b1;
         BR_EQ:     br_taken = (rdata1 == rdata2);
         BR_NE:     br_taken = (rdata1 != rdata2);
         BR_LT:     br_taken = ($signed(rdata1) < $signed(rdata2));
         BR_GE:     br_taken = ($signed(rdata1) >= $signed(rdata2));
         BR_LTU:    br_taken = (rdata1 < rdata2);
         BR_GEU:    br_taken = (rdata1 >= rdata2);
         default:   br_taken = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ysyx_exec_datapath.sv
// Testbench for ysyx_exec_datapath: scoreboard of expected outputs pushed
// alongside stimulus and popped when the outputs are sampled.
module tb_ysyx_exec_datapath;

   logic        clk;
   logic        rst_n;
   logic        rf_wr_en;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_func;
   logic [31:0] alu_out;
   logic [2:0]  br_type;
   logic        br_taken;

   int compare_cnt;
   int mismatch_cnt;

   typedef enum int {P_RDATA1, P_RDATA2, P_ALU, P_BR} port_e;

   typedef struct {
      string       tag;
      port_e       port;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];

   ysyx_exec_datapath dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rf_wr_en (rf_wr_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_func (alu_func),
      .alu_out  (alu_out),
      .br_type  (br_type),
      .br_taken (br_taken)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compare_cnt++;
      if (actual !== expected) begin
         mismatch_cnt++;
         $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
      end
   endtask

   task automatic expectOut(input string tag, input port_e port, input logic [31:0] exp);
      exp_t e;
      e.tag  = tag;
      e.port = port;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   // Let combinational outputs settle, then pop and compare every pending entry
   task automatic drainScoreboard();
      exp_t e;
      logic [31:0] act;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.port)
            P_RDATA1: act = rdata1;
            P_RDATA2: act = rdata2;
            P_ALU:    act = alu_out;
            default:  act = {31'b0, br_taken};
         endcase
         checkOutput(e.tag, act, e.exp);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [3:0] func,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp);
      alu_func = func;
      alu_a    = a;
      alu_b    = b;
      expectOut(tag, P_ALU, exp);
      drainScoreboard();
   endtask

   task automatic applyBranch(input string tag, input logic [2:0] bt, input logic exp);
      br_type = bt;
      expectOut(tag, P_BR, {31'b0, exp});
      drainScoreboard();
   endtask

   task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      rf_wr_en = 1'b1;
      waddr    = addr;
      wdata    = data;
      @(posedge clk);
      #1;
      rf_wr_en = 1'b0;
   endtask

   task automatic readRegs(input string tag, input logic [4:0] a1, input logic [31:0] e1,
                           input logic [4:0] a2, input logic [31:0] e2);
      raddr1 = a1;
      raddr2 = a2;
      expectOut({tag, "_rd1"}, P_RDATA1, e1);
      expectOut({tag, "_rd2"}, P_RDATA2, e2);
      drainScoreboard();
   endtask

   initial begin
      logic [31:0] rdw_exp;
      compare_cnt  = 0;
      mismatch_cnt = 0;
      rst_n    = 1'b0;
      rf_wr_en = 1'b0;
      waddr    = '0;
      wdata    = '0;
      raddr1   = '0;
      raddr2   = '0;
      alu_a    = '0;
      alu_b    = '0;
      alu_func = 4'b0000;
      br_type  = 3'b000;

      // Reset state
      #12;
      readRegs("reset", 5'd3, 32'h0, 5'd31, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset mid-run clears a written register without an edge
      writeReg(5'd5, 32'hDEADBEEF);
      readRegs("x5_written", 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
      #1;
      rst_n = 1'b0;
      readRegs("x5_async_rst", 5'd5, 32'h0, 5'd5, 32'h0);

      // Writes are blocked while reset is held
      @(negedge clk);
      rf_wr_en = 1'b1;
      waddr    = 5'd4;
      wdata    = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      rf_wr_en = 1'b0;
      rst_n    = 1'b1;
      readRegs("rst_blocks_wr", 5'd4, 32'h0, 5'd5, 32'h0);

      // x0 ignores writes
      writeReg(5'd0, 32'h00001234);
      readRegs("x0_write", 5'd0, 32'h0, 5'd0, 32'h0);

      // Consecutive writes to x1 and x2
      writeReg(5'd1, 32'h00000010);
      writeReg(5'd2, 32'hFFFFFFF0);
      readRegs("x1x2", 5'd1, 32'h00000010, 5'd2, 32'hFFFFFFF0);

      // Read-during-write on x3, and x0 stays zero under a same-index write
      writeReg(5'd3, 32'h000000AA);
`ifdef YSYX_RF_BYPASS_EN
      rdw_exp = 32'h00000055;
`else
      rdw_exp = 32'h000000AA;
`endif
      @(negedge clk);
      rf_wr_en = 1'b1;
      waddr    = 5'd3;
      wdata    = 32'h00000055;
      readRegs("rdw_x3", 5'd3, rdw_exp, 5'd1, 32'h00000010);
      @(posedge clk);
      readRegs("after_wr_x3", 5'd3, 32'h00000055, 5'd2, 32'hFFFFFFF0);
      @(negedge clk);
      waddr = 5'd0;
      wdata = 32'hFFFFFFFF;
      readRegs("rdw_x0", 5'd0, 32'h0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      rf_wr_en = 1'b0;
      readRegs("x0_after", 5'd0, 32'h0, 5'd3, 32'h00000055);

      // ALU arithmetic, logic and shifts
      applyStimulus("add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
      applyStimulus("add",       4'b0000, 32'h00001234, 32'h00000111, 32'h00001345);
      applyStimulus("sub_wrap",  4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);
      applyStimulus("sub",       4'b1000, 32'h00000100, 32'h00000001, 32'h000000FF);
      applyStimulus("slt",       4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
      applyStimulus("slt_f",     4'b0010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000);
      applyStimulus("sltu",      4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
      applyStimulus("sltu_t",    4'b0011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001);
      applyStimulus("sra",       4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000);
      applyStimulus("srl",       4'b0101, 32'h80000000, 32'h00000024, 32'h08000000);
      applyStimulus("sll",       4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000);
      applyStimulus("xor",       4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
      applyStimulus("or",        4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
      applyStimulus("and",       4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
      applyStimulus("copy_b",    4'b1111, 32'hAAAAAAAA, 32'h12345000, 32'h12345000);
      applyStimulus("bad_1010",  4'b1010, 32'hFFFFFFFF, 32'h12345678, 32'h00000000);

      // Branches with rs1 = x1 = 0xFFFFFFF0 and rs2 = x2 = 0x10
      writeReg(5'd1, 32'hFFFFFFF0);
      writeReg(5'd2, 32'h00000010);
      raddr1 = 5'd1;
      raddr2 = 5'd2;
      applyBranch("br_lt",     3'b100, 1'b1);
      applyBranch("br_ltu",    3'b110, 1'b0);
      applyBranch("br_ge",     3'b101, 1'b0);
      applyBranch("br_geu",    3'b111, 1'b1);
      applyBranch("br_eq",     3'b010, 1'b0);
      applyBranch("br_ne",     3'b011, 1'b1);
      applyBranch("br_never",  3'b000, 1'b0);
      applyBranch("br_always", 3'b001, 1'b1);

      // Equal operands
      raddr2 = 5'd1;
      applyBranch("br_eq_same", 3'b010, 1'b1);
      applyBranch("br_ne_same", 3'b011, 1'b0);
      applyBranch("br_ge_same", 3'b101, 1'b1);
      applyBranch("br_lt_same", 3'b100, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
      $finish;
   end

endmodule
